// File: rtl/se_pkg.sv
// Shared definitions for the sound-effect arbiter: default frequency width and FSM states.
package se_pkg;
  localparam int unsigned SE_FREQ_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    PLAY,
    GAP
  } se_state_t;
endpackage

// File: rtl/se_prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins, valid flags any request.
module se_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the last hit is the lowest set index.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/se_arbiter.sv
// Shares one tone generator among N score players: latches triggers, grants by fixed
// priority with optional preemption, forwards the owner's tone and inserts a silent gap.
module se_arbiter
  import se_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned FREQ_W        = SE_FREQ_W,
  parameter int unsigned GAP_CYCLES    = 50000,
  parameter int unsigned START_TIMEOUT = 16,
  parameter int unsigned PREEMPT       = 1
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic [N-1:0]        iReq,
  input  logic [N-1:0]        iSrcEnable,
  input  logic [N*FREQ_W-1:0] iSrcFreq,
  output logic [N-1:0]        oTrig,
  output logic [N-1:0]        oGrant,
  output logic                oEnable,
  output logic [FREQ_W-1:0]   oFreq,
  output logic                oBusy
);

  localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TMAX     = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int unsigned TW       = $clog2(TMAX + 1);
  localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
  localparam int unsigned ST_LAST  = (START_TIMEOUT == 0) ? 0 : START_TIMEOUT - 1;

  se_state_t          state, state_n;
  logic [N-1:0]       pending, pending_n;
  logic [IDX_W-1:0]   sel, sel_n;
  logic [TW-1:0]      timer, timer_n;
  logic [N-1:0]       trig_n, grant_n, clr_mask;
  logic               enable_n, busy_n, grant_new;
  logic [FREQ_W-1:0]  freq_n;
  logic               enc_valid;
  logic [IDX_W-1:0]   enc_idx;

  se_prio_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
    .req   (pending),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // State register and registered outputs; reset silences the tone generator immediately.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state   <= IDLE;
      pending <= '0;
      sel     <= '0;
      timer   <= '0;
      oTrig   <= '0;
      oGrant  <= '0;
      oEnable <= 1'b0;
      oFreq   <= '0;
      oBusy   <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      sel     <= sel_n;
      timer   <= timer_n;
      oTrig   <= trig_n;
      oGrant  <= grant_n;
      oEnable <= enable_n;
      oFreq   <= freq_n;
      oBusy   <= busy_n;
    end
  end

  // Next-state, pending bookkeeping and next output values.
  always_comb begin
    state_n   = state;
    sel_n     = sel;
    timer_n   = timer;
    clr_mask  = '0;
    trig_n    = '0;
    grant_new = 1'b0;
    grant_n   = '0;
    enable_n  = 1'b0;
    freq_n    = '0;
    busy_n    = 1'b0;

    case (state)
      IDLE: begin
        if (enc_valid) grant_new = 1'b1;
      end
      WAIT_START: begin
        if (iSrcEnable[sel]) begin
          state_n = PLAY;
        end else if (timer == TW'(ST_LAST)) begin
          timer_n = '0;
          state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      PLAY: begin
        if (!iSrcEnable[sel]) begin
          timer_n = '0;
          state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else if (PREEMPT != 0 && enc_valid && enc_idx < sel) begin
          grant_new = 1'b1;
        end
      end
      GAP: begin
        if (timer == TW'(GAP_LAST)) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // A fresh grant (from IDLE or by preemption) pulses the winner's start line.
    if (grant_new) begin
      sel_n    = enc_idx;
      clr_mask = N'(1) << enc_idx;
      trig_n   = clr_mask;
      timer_n  = '0;
      state_n  = WAIT_START;
    end

    // A request in the grant cycle re-queues: set wins over clear.
    pending_n = (pending & ~clr_mask) | iReq;

    if (state_n == WAIT_START || state_n == PLAY) grant_n = N'(1) << sel_n;
    enable_n = (state_n == PLAY);
    busy_n   = (state_n != IDLE);
    for (int i = 0; i < N; i++) begin
      if (enable_n && sel_n == IDX_W'(i)) freq_n = iSrcFreq[i*FREQ_W +: FREQ_W];
    end
  end

endmodule

// File: tb/tb_se_arbiter.sv
// Directed self-checking bench for se_arbiter with simple score-player models.
module tb_se_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned FW = 16;

  logic            iClock = 1'b0;
  logic            iReset;
  logic [N-1:0]    iReq;
  logic [N-1:0]    iSrcEnable;
  logic [N*FW-1:0] iSrcFreq;
  logic [N-1:0]    oTrig;
  logic [N-1:0]    oGrant;
  logic            oEnable;
  logic [FW-1:0]   oFreq;
  logic            oBusy;

  logic [N-1:0]    dead;
  logic [4:0]      cnt [N];

  int checks   = 0;
  int failures = 0;

  int m_en, m_gap, m_wait, m_ferr, m_trig_err;
  int m_trig [N];
  logic [N-1:0] m_first;

  se_arbiter #(
    .N(N), .FREQ_W(FW), .GAP_CYCLES(4), .START_TIMEOUT(8), .PREEMPT(1)
  ) dut (
    .iClock     (iClock),
    .iReset     (iReset),
    .iReq       (iReq),
    .iSrcEnable (iSrcEnable),
    .iSrcFreq   (iSrcFreq),
    .oTrig      (oTrig),
    .oGrant     (oGrant),
    .oEnable    (oEnable),
    .oFreq      (oFreq),
    .oBusy      (oBusy)
  );

  always #5 iClock = ~iClock;

  assign iSrcFreq = {16'd1300, 16'd1200, 16'd1100, 16'd1000};

  // Score player model: enable rises the cycle after its trigger and holds 20 cycles.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (oTrig[i] && !dead[i]) cnt[i] <= 5'd20;
        else if (cnt[i] != 5'd0)  cnt[i] <= cnt[i] - 5'd1;
      end
    end
  end

  always_comb begin
    iSrcEnable = '0;
    for (int i = 0; i < N; i++) iSrcEnable[i] = (cnt[i] != 5'd0);
  end

  task automatic tick();
    @(posedge iClock);
    @(negedge iClock);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Watch outputs until the arbiter has been idle for 3 samples, tallying behaviour.
  task automatic monitor();
    int idle_run;
    logic [N-1:0] prev_trig;
    logic done;
    int idx;
    m_en = 0; m_gap = 0; m_wait = 0; m_ferr = 0; m_trig_err = 0;
    m_first = '0; prev_trig = '0; idle_run = 0; done = 1'b0;
    for (int i = 0; i < N; i++) m_trig[i] = 0;
    for (int c = 0; c < 300; c++) begin
      if (oTrig != '0) begin
        if ($countones(oTrig) != 1 || prev_trig != '0) m_trig_err++;
        for (int i = 0; i < N; i++) if (oTrig[i]) m_trig[i]++;
        if (m_first == '0) m_first = oTrig;
      end
      prev_trig = oTrig;
      if (oEnable) begin
        m_en++;
        idx = 0;
        for (int i = 0; i < N; i++) if (oGrant[i]) idx = i;
        if ($countones(oGrant) != 1 || oFreq != FW'(1000 + 100 * idx)) m_ferr++;
      end else begin
        if (oFreq != '0) m_ferr++;
        if (oGrant != '0) m_wait++;
        else if (oBusy) m_gap++;
      end
      if (!oBusy) idle_run++;
      else idle_run = 0;
      if (idle_run == 3) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("monitor_done", 32'(done), 32'd1);
  endtask

  initial begin
    iReset = 1'b1;
    iReq   = '0;
    dead   = '0;
    tick();
    check("rst_trig", 32'(oTrig), 32'd0);
    check("rst_grant", 32'(oGrant), 32'd0);
    check("rst_enable", 32'(oEnable), 32'd0);
    check("rst_freq", 32'(oFreq), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    iReset = 1'b0;
    tick();
    tick();
    check("idle_busy", 32'(oBusy), 32'd0);

    // Single request from source 2
    iReq = 4'b0100;
    tick();
    iReq = '0;
    check("s1_trig_early", 32'(oTrig), 32'd0);
    tick();
    check("s1_trig", 32'(oTrig), 32'b0100);
    check("s1_grant", 32'(oGrant), 32'b0100);
    check("s1_busy", 32'(oBusy), 32'd1);
    check("s1_en_wait", 32'(oEnable), 32'd0);
    tick();
    check("s1_trig_once", 32'(oTrig), 32'd0);
    check("s1_en_wait2", 32'(oEnable), 32'd0);
    tick();
    check("s1_en", 32'(oEnable), 32'd1);
    check("s1_freq", 32'(oFreq), 32'd1200);
    monitor();
    check("s1_en_cycles", 32'(m_en), 32'd20);
    check("s1_gap_cycles", 32'(m_gap), 32'd4);
    check("s1_freq_err", 32'(m_ferr), 32'd0);
    check("s1_trig_err", 32'(m_trig_err), 32'd0);

    // Simultaneous requests 1 and 3
    iReq = 4'b1010;
    tick();
    iReq = '0;
    tick();
    monitor();
    check("s2_first", 32'(m_first), 32'b0010);
    check("s2_trig1", 32'(m_trig[1]), 32'd1);
    check("s2_trig3", 32'(m_trig[3]), 32'd1);
    check("s2_trig0", 32'(m_trig[0] + m_trig[2]), 32'd0);
    check("s2_en_cycles", 32'(m_en), 32'd40);
    check("s2_gap_cycles", 32'(m_gap), 32'd8);
    check("s2_wait_cycles", 32'(m_wait), 32'd4);
    check("s2_freq_err", 32'(m_ferr), 32'd0);
    check("s2_trig_err", 32'(m_trig_err), 32'd0);

    // Preemption of source 3 by source 0
    iReq = 4'b1000;
    tick();
    iReq = '0;
    tick();
    tick();
    tick();
    check("s3_play3", 32'(oFreq), 32'd1300);
    repeat (9) tick();
    iReq = 4'b0001;
    tick();
    iReq = '0;
    check("s3_pre_trig", 32'(oTrig), 32'd0);
    check("s3_pre_en", 32'(oEnable), 32'd1);
    tick();
    check("s3_trig0", 32'(oTrig), 32'b0001);
    check("s3_grant0", 32'(oGrant), 32'b0001);
    check("s3_muted", 32'(oEnable), 32'd0);
    check("s3_muted_freq", 32'(oFreq), 32'd0);
    tick();
    tick();
    check("s3_en0", 32'(oEnable), 32'd1);
    check("s3_freq0", 32'(oFreq), 32'd1000);
    monitor();
    check("s3_no_replay", 32'(m_trig[3]), 32'd0);
    check("s3_en_cycles", 32'(m_en), 32'd20);
    check("s3_gap_cycles", 32'(m_gap), 32'd4);
    check("s3_freq_err", 32'(m_ferr), 32'd0);

    // Start timeout on a silent source 1
    dead = 4'b0010;
    iReq = 4'b0010;
    tick();
    iReq = '0;
    tick();
    check("s4_trig", 32'(oTrig), 32'b0010);
    monitor();
    check("s4_wait_cycles", 32'(m_wait), 32'd8);
    check("s4_gap_cycles", 32'(m_gap), 32'd4);
    check("s4_en_cycles", 32'(m_en), 32'd0);
    check("s4_trig_count", 32'(m_trig[1]), 32'd1);
    dead = '0;

    // Held request merges, plus one re-queue at the grant edge
    iReq = 4'b0100;
    tick();
    tick();
    check("s5_trig", 32'(oTrig), 32'b0100);
    tick();
    tick();
    tick();
    iReq = '0;
    monitor();
    check("s5_second_trig", 32'(m_trig[2]), 32'd1);
    check("s5_en_cycles", 32'(m_en), 32'd39);
    check("s5_gap_cycles", 32'(m_gap), 32'd8);
    check("s5_trig_err", 32'(m_trig_err), 32'd0);

    // Async reset mid-play with a pending lower-priority request
    iReq = 4'b0100;
    tick();
    iReq = '0;
    tick();
    tick();
    tick();
    iReq = 4'b1000;
    tick();
    iReq = '0;
    check("s6_playing", 32'(oEnable), 32'd1);
    #2 iReset = 1'b1;
    #1;
    check("s6_rst_en", 32'(oEnable), 32'd0);
    check("s6_rst_freq", 32'(oFreq), 32'd0);
    check("s6_rst_grant", 32'(oGrant), 32'd0);
    check("s6_rst_busy", 32'(oBusy), 32'd0);
    @(posedge iClock);
    @(negedge iClock);
    iReset = 1'b0;
    monitor();
    check("s6_pending_clr", 32'(m_trig[0] + m_trig[1] + m_trig[2] + m_trig[3]), 32'd0);
    check("s6_en_cycles", 32'(m_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
